// File: rtl/selec_config_ctrl_if.sv
// Config write port for selec_config_ctrl: valid/ready beats plus
// the error and commit-done pulses returned to the host.
interface selec_config_ctrl_if #(
    parameter int ADDR_W  = 4,
    parameter int FIELD_W = 11
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [FIELD_W-1:0] cfg_field;
    logic               cfg_commit;
    logic               cfg_err;
    logic               commit_done;

    modport master (
        output cfg_valid, cfg_addr, cfg_field, cfg_commit,
        input  cfg_ready, cfg_err, commit_done
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_field, cfg_commit,
        output cfg_ready, cfg_err, commit_done
    );
endinterface

// File: rtl/selec_config_ctrl.sv
// Shadowed select-field configuration for data_selector; commits the
// shadow to wSelec behind a busy window so consumers can drain first.
module selec_config_ctrl #(
    parameter int MAIN_INPUTS              = 16,
    parameter int REGS_INPUTS              = 64,
    parameter int SELECTOR_OUTPUTS         = 4,
    parameter int SELECTOR_OUTPUTS_PER_BUS = 4,
    parameter int HOLD_CYCLES              = 2,
    localparam int MAIN_W     = $clog2(MAIN_INPUTS),
    localparam int REG_W      = $clog2(REGS_INPUTS + 1),
    localparam int FIELD_W    = MAIN_W + REG_W,
    localparam int NUM_FIELDS = SELECTOR_OUTPUTS * SELECTOR_OUTPUTS_PER_BUS,
    localparam int SEL_W      = NUM_FIELDS * FIELD_W
) (
    input  logic              clk,
    input  logic              rst,
    selec_config_ctrl_if.slave cfg,
    output logic              wBusy,
    output logic [SEL_W-1:0]  wSelec
);
    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        UPDATE,
        SETTLE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [7:0]       cnt;
    logic [7:0]       cnt_n;
    logic [SEL_W-1:0] shadow;
    logic [REG_W-1:0] reg_idx;
    logic             legal;
    logic             accept;
    logic             start;

    assign reg_idx = cfg.cfg_field[FIELD_W-1 -: REG_W];
    // reg_idx == REGS_INPUTS is the "no register source" code
    assign legal   = reg_idx <= REG_W'(REGS_INPUTS);
    assign accept  = cfg.cfg_valid && cfg.cfg_ready;
    assign start   = accept && cfg.cfg_commit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = DRAIN;
                    cnt_n   = 8'(HOLD_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt == 8'd0) begin
                    state_n = UPDATE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            UPDATE: state_n = SETTLE;
            SETTLE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow          <= '0;
            wSelec          <= '0;
            wBusy           <= 1'b0;
            cfg.cfg_ready   <= 1'b1;
            cfg.cfg_err     <= 1'b0;
            cfg.commit_done <= 1'b0;
        end else begin
            cfg.cfg_err     <= accept && !legal;
            cfg.commit_done <= state == SETTLE;
            if (accept && legal) begin
                shadow[cfg.cfg_addr*FIELD_W +: FIELD_W] <= cfg.cfg_field;
            end
            if (state == UPDATE) begin
                wSelec <= shadow;
            end
            if (start) begin
                wBusy         <= 1'b1;
                cfg.cfg_ready <= 1'b0;
            end else if (state == SETTLE) begin
                wBusy         <= 1'b0;
                cfg.cfg_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_selec_config_ctrl.sv
// Bench for selec_config_ctrl: vector table, scoreboard of committed
// words, and hand sequences for hold, reset and busy-width cases.
module tb_selec_config_ctrl;
    localparam int FW = 11;
    localparam int W  = 176;
    localparam int H  = 2;

    typedef struct {
        logic [3:0]  addr;
        logic [10:0] field;
        bit          commit;
        bit          err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    selec_config_ctrl_if #(.ADDR_W(4), .FIELD_W(FW)) m ();
    selec_config_ctrl_if #(.ADDR_W(4), .FIELD_W(FW)) i1 ();
    selec_config_ctrl_if #(.ADDR_W(4), .FIELD_W(FW)) i8 ();

    assign i1.cfg_valid  = m.cfg_valid;
    assign i1.cfg_addr   = m.cfg_addr;
    assign i1.cfg_field  = m.cfg_field;
    assign i1.cfg_commit = m.cfg_commit;
    assign i8.cfg_valid  = m.cfg_valid;
    assign i8.cfg_addr   = m.cfg_addr;
    assign i8.cfg_field  = m.cfg_field;
    assign i8.cfg_commit = m.cfg_commit;

    logic [W-1:0] sel2, sel1, sel8;
    logic         busy2, busy1, busy8;

    selec_config_ctrl #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .cfg(m),
        .wBusy(busy2), .wSelec(sel2)
    );
    selec_config_ctrl #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .cfg(i1),
        .wBusy(busy1), .wSelec(sel1)
    );
    selec_config_ctrl #(.HOLD_CYCLES(8)) dut8 (
        .clk(clk), .rst(rst), .cfg(i8),
        .wBusy(busy8), .wSelec(sel8)
    );

    int           nvec = 0;
    int           nmis = 0;
    logic [W-1:0] mshadow = '0;
    logic [W-1:0] live = '0;
    logic [W-1:0] sb[$];
    int           bcnt[3] = '{0, 0, 0};
    int           bw[3] = '{0, 0, 0};
    vec_t         vt[9];

    function automatic void chk(string nm, logic [255:0] act,
                                logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        logic [2:0] b;
        b = {busy8, busy1, busy2};
        for (int i = 0; i < 3; i++) begin
            if (b[i]) begin
                bcnt[i]++;
            end else if (bcnt[i] != 0) begin
                bw[i]   = bcnt[i];
                bcnt[i] = 0;
            end
        end
        if (rst && m.commit_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                live = sb.pop_front();
                chk("wselec_commit", sel2, live);
                chk("busy_width", bw[0], H + 2);
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [10:0] f,
                        input bit c, output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        m.cfg_valid  = 1'b1;
        m.cfg_addr   = a;
        m.cfg_field  = f;
        m.cfg_commit = c;
        do begin
            ok = m.cfg_ready;
            @(negedge clk);
            n++;
        end while (!ok && n < 64);
        m.cfg_valid  = 1'b0;
        m.cfg_commit = 1'b0;
        chk("beat_accepted", ok, 1);
        if (ok) begin
            if (f[10:4] <= 7'd64) mshadow[a*FW +: FW] = f;
            if (c) sb.push_back(mshadow);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || !m.cfg_ready) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", k < 40, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int           n;
        logic [W-1:0] old;
        logic [W-1:0] nxt;

        vt[0] = '{4'd0,  {7'd5,   4'd3},  1'b0, 1'b0};
        vt[1] = '{4'd15, {7'd64,  4'd15}, 1'b0, 1'b0};
        vt[2] = '{4'd1,  {7'd0,   4'd1},  1'b1, 1'b0};
        vt[3] = '{4'd2,  {7'd65,  4'd0},  1'b0, 1'b1};
        vt[4] = '{4'd2,  {7'd127, 4'd7},  1'b0, 1'b1};
        vt[5] = '{4'd4,  {7'd63,  4'd9},  1'b0, 1'b0};
        vt[6] = '{4'd0,  {7'd10,  4'd2},  1'b0, 1'b0};
        vt[7] = '{4'd2,  {7'd66,  4'd1},  1'b1, 1'b1};
        vt[8] = '{4'd7,  {7'd64,  4'd0},  1'b1, 1'b0};

        m.cfg_valid  = 1'b0;
        m.cfg_addr   = '0;
        m.cfg_field  = '0;
        m.cfg_commit = 1'b0;

        // held in reset while inputs toggle randomly
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_wselec", sel2, 0);
            chk("rst_flags",
                {busy2, m.cfg_ready, m.cfg_err, m.commit_done},
                4'b0100);
            m.cfg_valid  = 1'($urandom);
            m.cfg_addr   = 4'($urandom);
            m.cfg_field  = 11'($urandom);
            m.cfg_commit = 1'($urandom);
        end
        m.cfg_valid  = 1'b0;
        m.cfg_commit = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send(vt[i].addr, vt[i].field, vt[i].commit, n);
            chk($sformatf("err_v%0d", i), m.cfg_err, vt[i].err);
            @(negedge clk);
            chk("err_clear", m.cfg_err, 0);
            if (vt[i].commit) wait_idle();
        end

        // wSelec moves exactly H+1 edges after the commit beat
        send(4'd5, {7'd20, 4'd6}, 1'b0, n);
        old = live;
        send(4'd9, {7'd64, 4'd0}, 1'b1, n);
        nxt = mshadow;
        for (int k = 1; k <= H + 2; k++) begin
            @(negedge clk);
            if (k == H) chk("wsel_hold", sel2, old);
            if (k == H + 1) begin
                chk("wsel_upd", sel2, nxt);
                chk("busy_upd", busy2, 1);
            end
            if (k == H + 2) begin
                chk("done_pulse", m.commit_done, 1);
                chk("ready_back", m.cfg_ready, 1);
            end
            if (k < H + 2) chk("ready_low", m.cfg_ready, 0);
        end
        @(negedge clk);
        chk("done_once", m.commit_done, 0);
        wait_idle();

        // beat offered during DRAIN waits for the first IDLE edge
        send(4'd3, {7'd1, 4'd1}, 1'b1, n);
        send(4'd6, {7'd33, 4'd12}, 1'b0, n);
        chk("held_accept_edge", n, H + 3);
        wait_idle();
        send(4'd11, {7'd7, 4'd5}, 1'b1, n);
        wait_idle();

        // reset while in UPDATE
        send(4'd8, {7'd40, 4'd4}, 1'b0, n);
        send(4'd10, {7'd2, 4'd2}, 1'b1, n);
        repeat (H) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_wselec", sel2, 0);
        chk("midrst_flags",
            {busy2, m.cfg_ready, m.cfg_err, m.commit_done},
            4'b0100);
        sb.delete();
        mshadow = '0;
        live    = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(4'd0, 11'd0, 1'b1, n);
        wait_idle();
        chk("post_rst_wselec", sel2, 0);

        // busy width across HOLD_CYCLES settings
        repeat (20) @(negedge clk);
        send(4'd1, {7'd3, 4'd3}, 1'b1, n);
        repeat (14) @(negedge clk);
        chk("width_h2", bw[0], 4);
        chk("width_h1", bw[1], 3);
        chk("width_h8", bw[2], 10);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end
endmodule
